// File: rtl/core_types_pkg.sv
// Shared core types used by the pipeline hazard/sequencing controller.
package core_types_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } pipe_ctrl_state_e;

   typedef struct packed {
      logic stall_if;
      logic stall_dec;
      logic stall_exe;
      logic stall_mem;
      logic flush_dec;
      logic flush_exe;
      logic pc_redirect;
   } pipe_ctrl_out_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Data-memory wait sequencer: counts consecutive wait cycles and latches a
// sticky timeout fault that only reset clears.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | no outstanding memory wait
// MEM_WAIT | access pending, wait_cnt counts consecutive wait cycles
// FAULT    | wait exceeded MEM_TIMEOUT; pipeline frozen until reset
module mem_wait_timer
   import core_types_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             mem_req,
   input  logic             mem_ready,
   output pipe_ctrl_state_e state,
   output logic             fault
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   logic [WAIT_W-1:0] wait_cnt;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state    <= RUN;
         wait_cnt <= '0;
         fault    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mem_req && !mem_ready) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                  state <= FAULT;
                  fault <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            FAULT: begin
               fault <= 1'b1;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use, redirect
// and memory-wait stalls/flushes. Optional perf counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import core_types_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic                  Clock,
   input  logic                  nReset,
   input  logic [REG_ADDR_W-1:0] dec_rs1,
   input  logic [REG_ADDR_W-1:0] dec_rs2,
   input  logic                  dec_rs1_used,
   input  logic                  dec_rs2_used,
   input  logic [REG_ADDR_W-1:0] exe_rd,
   input  logic                  exe_mem_read,
   input  logic                  exe_redirect,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   output logic                  stall_if,
   output logic                  stall_dec,
   output logic                  stall_exe,
   output logic                  stall_mem,
   output logic                  flush_dec,
   output logic                  flush_exe,
   output logic                  pc_redirect,
   output logic                  fault,
   output logic [CNT_W-1:0]      perf_stall_cnt,
   output logic [CNT_W-1:0]      perf_flush_cnt
);

   pipe_ctrl_state_e state;
   pipe_ctrl_out_t   ctl;
   logic             mem_stall;
   logic             load_use;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait_timer (
      .Clock     (Clock),
      .nReset    (nReset),
      .mem_req   (mem_req),
      .mem_ready (mem_ready),
      .state     (state),
      .fault     (fault)
   );

   assign mem_stall = (mem_req && !mem_ready) || (state == FAULT);

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign load_use = exe_mem_read && (exe_rd != '0) &&
                     ((dec_rs1_used && (dec_rs1 == exe_rd)) ||
                      (dec_rs2_used && (dec_rs2 == exe_rd)));

   // Memory wait freezes everything; a redirect kills the dependent instruction
   always_comb begin
      ctl = '0;
      if (mem_stall) begin
         ctl.stall_if  = 1'b1;
         ctl.stall_dec = 1'b1;
         ctl.stall_exe = 1'b1;
         ctl.stall_mem = 1'b1;
      end else if (exe_redirect) begin
         ctl.flush_dec   = 1'b1;
         ctl.flush_exe   = 1'b1;
         ctl.pc_redirect = 1'b1;
      end else if (load_use) begin
         ctl.stall_if  = 1'b1;
         ctl.stall_dec = 1'b1;
         ctl.flush_exe = 1'b1;
      end
   end

   assign stall_if    = ctl.stall_if;
   assign stall_dec   = ctl.stall_dec;
   assign stall_exe   = ctl.stall_exe;
   assign stall_mem   = ctl.stall_mem;
   assign flush_dec   = ctl.flush_dec;
   assign flush_exe   = ctl.flush_exe;
   assign pc_redirect = ctl.pc_redirect;

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (ctl.stall_if && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
         if (ctl.pc_redirect && (perf_flush_cnt != '1))
            perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      end
   end
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage core (IF, DEC, EXE, MEM, WB).
- Watches DEC source registers, the EXE destination register and load flag, the EXE branch redirect, and the data-memory handshake.
- Drives per-stage stall and flush enables plus a sticky memory-timeout fault.
- Instantiated once in core, beside forwarding; forwarding covers ALU-to-ALU hazards, pipe_ctrl covers load-use, control and memory-wait hazards.

Parameters:
- REG_ADDR_W, 5: register address width.
- MEM_TIMEOUT, 15: maximum consecutive data-memory wait cycles before fault; must be at least 1.
- CNT_W, 32: width of performance counters (optional feature only).

Ports:
- Clock  in  1  rising-edge clock
- nReset  in  1  asynchronous active-low reset
- dec_rs1  in  REG_ADDR_W  DEC source register 1 address
- dec_rs2  in  REG_ADDR_W  DEC source register 2 address
- dec_rs1_used  in  1  DEC instruction reads rs1
- dec_rs2_used  in  1  DEC instruction reads rs2
- exe_rd  in  REG_ADDR_W  EXE destination register
- exe_mem_read  in  1  EXE instruction is a load
- exe_redirect  in  1  EXE branch/jump taken or mispredicted
- mem_req  in  1  MEM stage issuing a data-memory access this cycle
- mem_ready  in  1  data memory completes the access this cycle
- stall_if  out  1  hold PC and IF register
- stall_dec  out  1  hold DEC register
- stall_exe  out  1  hold EXE register
- stall_mem  out  1  hold MEM register
- flush_dec  out  1  load bubble into DEC register
- flush_exe  out  1  load bubble into EXE register
- pc_redirect  out  1  PC takes branch target
- fault  out  1  sticky memory timeout
- perf_stall_cnt  out  CNT_W  stall cycle counter
- perf_flush_cnt  out  CNT_W  redirect event counter

Behaviour:
- Interface: one clock, Clock; reset nReset is asynchronous, active-low.
- Stall/flush outputs are combinational from inputs and the registered state, so they take effect in the same cycle.
- State, wait counter, fault and perf counters are registered.
- FSM states: RUN, MEM_WAIT, FAULT.
- Reset: state=RUN, wait_cnt=0, fault=0, perf counters 0. With all inputs 0, every output is 0.
- Reset asserted mid-wait or in FAULT returns to RUN immediately.
- mem_stall = (mem_req && !mem_ready) || state==FAULT.
- When mem_stall=1:
  - stall_if, stall_dec, stall_exe and stall_mem are all 1.
  - flush_* and pc_redirect are 0.
  - Redirect and load-use are ignored that cycle. EXE is frozen, so its inputs persist and are acted on in the first cycle mem_stall=0.
- RUN to MEM_WAIT: on mem_req && !mem_ready; wait_cnt<=1.
- MEM_WAIT, mem_ready=1: go to RUN; wait_cnt<=0. The pipeline advances in that same cycle (stalls drop).
- MEM_WAIT, mem_ready=0: wait_cnt++.
- MEM_WAIT to FAULT: when wait_cnt==MEM_TIMEOUT and mem_ready=0.
- FAULT: fault=1, all stalls held; exit only by reset.
- wait_cnt width: $clog2(MEM_TIMEOUT+1).
- Redirect, when mem_stall=0 and exe_redirect=1:
  - flush_dec=1, flush_exe=1, pc_redirect=1 for one cycle.
  - No stalls.
  - Takes priority over load-use, since the dependent instruction is killed.
- Load-use, when mem_stall=0, exe_redirect=0, exe_mem_read=1, exe_rd!=0, and (dec_rs1_used && dec_rs1==exe_rd) or (dec_rs2_used && dec_rs2==exe_rd):
  - stall_if=1, stall_dec=1, flush_exe=1 for exactly one cycle.
  - The bubble moves into EXE, so the condition clears next cycle.
- Register x0 never causes a load-use stall.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every cycle with stall_if=1.
  - perf_flush_cnt increments on every cycle with pc_redirect=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports remain, tied to 0; no counter flops.

Decomposition:
- core_types_pkg additions:
  - pipe_ctrl_state_e enum {RUN, MEM_WAIT, FAULT}.
  - pipe_ctrl_out_t struct bundling the stall, flush and pc_redirect outputs, for core wiring.
- Sub-module mem_wait_timer holds the FSM, wait counter and fault flag. It outputs state and fault.
- pipe_ctrl top holds the combinational hazard logic and optional counters.

Test Plan:
- Load-use: exe_mem_read=1, exe_rd=5, dec_rs1=5, dec_rs1_used=1 -> one cycle of stall_if=1, stall_dec=1, flush_exe=1; with exe_rd=0 -> no stall.
- Redirect plus load-use: exe_redirect=1 with the load-use condition also true -> flush_dec=1, flush_exe=1, pc_redirect=1, stall_if=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then ready -> all four stalls high for exactly 3 cycles, state back to RUN, fault=0.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready never asserted -> fault=1 after the 5th wait cycle; stalls stay high; nReset low clears everything asynchronously.
- Redirect during wait: exe_redirect=1 while waiting 2 cycles -> pc_redirect=0 in both; pc_redirect=1 in the cycle mem_ready=1.
- PIPE_CTRL_PERF_EN: 2 load-use stalls plus 3 wait cycles -> perf_stall_cnt=5; 1 redirect -> perf_flush_cnt=1.
